// File: rtl/shift_add_mul_pkg.sv
// rtl/shift_add_mul_pkg.sv - shared FSM encoding and sizing helpers for the shift-add multiplier
// Contents:
//   state_e        2-bit FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   N_DEFAULT      default operand width
//   cnt_width()    iteration counter width for a given operand width, $clog2(n+1)
package shift_add_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned N_DEFAULT = 64;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(N_DEFAULT);

endpackage

// File: rtl/shift_add_mul_if.sv
// rtl/shift_add_mul_if.sv - request/result bundle between a multiply requester and the multiplier
// Signals:
//   start    requester -> multiplier, begin a multiply
//   a, b     requester -> multiplier, unsigned operands (N bits)
//   busy     multiplier -> requester, operation in progress
//   done     multiplier -> requester, one-cycle product-valid pulse
//   product  multiplier -> requester, 2N-bit unsigned result
interface shift_add_mul_if
  import shift_add_mul_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
);

  logic             start;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/shift_add_mul_add.sv
// rtl/shift_add_mul_add.sv - N-bit ripple adder with carry in and carry out
// Ports:
//   a_i, b_i  N-bit addends
//   c_i       carry in
//   sum_o     N-bit sum
//   c_o       carry out
module shift_add_mul_add #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] sum_o,
  output logic         c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, c_i};

endmodule

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - iterative unsigned shift-and-add multiplier, one partial product per cycle
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of shift_add_mul_if (start/a/b in, busy/done/product out)
module shift_add_mul
  import shift_add_mul_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  shift_add_mul_if.slave bus
);

  localparam int unsigned CW = cnt_width(N);

  state_e           state_q;
  logic [N-1:0]     mcand_q;
  logic [N-1:0]     acc_hi_q;
  logic [N-1:0]     acc_lo_q;   // starts as the multiplier, fills with product low bits
  logic [CW-1:0]    cnt_q;
  logic [2*N-1:0]   product_q;
  logic             busy_q;
  logic             done_q;

  logic [N-1:0]     add_b;
  logic [N-1:0]     sum;
  logic             carry;
  logic [N-1:0]     acc_hi_d;
  logic [N-1:0]     acc_lo_d;
  logic             last_iter;

  // Gating the addend makes the "no add" case fall out of the same adder with carry 0.
  assign add_b = acc_lo_q[0] ? mcand_q : '0;

  shift_add_mul_add #(.N(N)) u_add (
    .a_i   (acc_hi_q),
    .b_i   (add_b),
    .c_i   (1'b0),
    .sum_o (sum),
    .c_o   (carry)
  );

  // {carry, sum, acc_lo} >> 1
  assign acc_hi_d  = {carry, sum[N-1:1]};
  assign acc_lo_d  = {sum[0], acc_lo_q[N-1:1]};
  assign last_iter = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q  <= bus.a;
            acc_hi_q <= '0;
            acc_lo_q <= bus.b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_iter) begin
            product_q <= {acc_hi_d, acc_lo_d};
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 Parameter: N, default 64, operand width in bits; legal values 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on rising edge.
REQ-005 Port: a  input  N  unsigned multiplicand; sampled only on the accepting edge.
REQ-006 Port: b  input  N  unsigned multiplier; sampled only on the accepting edge.
REQ-007 Port: busy  output  1  high whenever state is not IDLE.
REQ-008 Port: done  output  1  single-cycle pulse; product is valid.
REQ-009 Port: product  output  2N  unsigned a*b; holds value until next accepted start.

Function
REQ-010 FSM states SHALL be exactly IDLE, RUN and DONE.
REQ-011 Start acceptance: start=1 at an edge in IDLE; a and b latched; iteration counter cleared; state moves to RUN.
REQ-012 start SHALL be ignored in RUN and DONE, with no effect on latched operands or result.
REQ-013 RUN iteration, one per edge, N in total:
- if multiplier LSB = 1: {carry, sum} = acc_hi + multiplicand;
- else: {carry, sum} = {0, acc_hi};
- then {acc_hi, acc_lo} = {carry, sum, acc_lo} >> 1.
REQ-014 After RUN edge N, state SHALL move to DONE and {acc_hi, acc_lo} SHALL equal a*b exactly; no overflow is possible.
REQ-015 Timing, with the accepting edge at k:
- done=1 for exactly the one cycle following edge k+N (the DONE state);
- state returns to IDLE at edge k+N+1.
REQ-016 product SHALL update only at edge k+N and SHALL remain stable until the next accepted start.
REQ-017 busy SHALL be 1 from edge k through edge k+N+1 exclusive, i.e. in RUN and DONE.
REQ-018 start=1 in the DONE cycle SHALL be ignored; a new start is accepted no earlier than the first IDLE cycle.
REQ-019 Back-to-back operation: minimum start-to-start spacing is N+2 cycles.
REQ-020 Operand zero (a=0 or b=0) SHALL still take the full N iterations and SHALL yield product=0.
REQ-021 Arithmetic is unsigned only; no sign handling and no early termination.

Reset
REQ-022 rst_n low SHALL immediately, without waiting for clk, force:
- state=IDLE;
- busy=0, done=0, product=0;
- operand registers and counter to 0.
REQ-023 Reset asserted mid-RUN or in DONE SHALL abort the operation; no done pulse is produced for it.
REQ-024 start SHALL be ignored while rst_n is low; the first acceptance is possible at the first rising edge after deassertion.

Structure
REQ-025 Shared package holds: FSM state encoding (IDLE=0, RUN=1, DONE=2, 2-bit) and the counter width constant $clog2(N+1).
REQ-026 The per-iteration add SHALL use the existing ADD module as the single sub-module:
- parameterised with N;
- c_in tied to 0;
- c_out supplies carry.
REQ-027 No other arithmetic sub-modules; the shift and counter logic are local.

Verification
REQ-028 Reset and idle:
- rst_n low mid-RUN -> busy=0, done=0, product=0 in the same cycle;
- start held during reset -> ignored.
REQ-029 Basic multiply: N=64, a=3, b=5, start one cycle ->
- busy high for 65 cycles;
- done pulses exactly once, 64 cycles after the accepting edge;
- product=15.
REQ-030 Maximum operands: a=b=0xFFFF_FFFF_FFFF_FFFF -> product=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-031 Ignored start: start re-pulsed in RUN with a=7, b=7; original a=0x1_0000_0000, b=0x1_0000_0000 ->
- product=0x1_0000_0000_0000_0000;
- timing unchanged.
REQ-032 Zero and back-to-back:
- a=0, b=0xDEAD -> product=0 after the full latency;
- then start in the first IDLE cycle with a=2, b=0x8000_0000_0000_0000 -> product=0x1_0000_0000_0000_0000;
- product holds 0 between the two operations.
REQ-033 Random: 1000 random unsigned a,b at N=64 and N=8, checked against a reference a*b; done count equals accepted start count.
